// File: rtl/turn_scheduler_if.sv
// Handshake bundle between game logic (master) and the turn scheduler (slave),
// including the per-player controller start/target/done lines.
interface turn_scheduler_if;
  logic       roll_valid;
  logic [2:0] roll_value;
  logic       roll_ready;
  logic       new_game;
  logic       move_start_p1;
  logic [9:0] target_x_p1;
  logic       turn_done_p1;
  logic       move_start_p2;
  logic [9:0] target_x_p2;
  logic       turn_done_p2;
  logic       active_player;
  logic       game_over;
  logic       winner;
  logic       bad_roll;
  logic       fault;

  modport master (
    output roll_valid, roll_value, new_game, turn_done_p1, turn_done_p2,
    input  roll_ready, move_start_p1, target_x_p1, move_start_p2, target_x_p2,
           active_player, game_over, winner, bad_roll, fault
  );

  modport slave (
    input  roll_valid, roll_value, new_game, turn_done_p1, turn_done_p2,
    output roll_ready, move_start_p1, target_x_p1, move_start_p2, target_x_p2,
           active_player, game_over, winner, bad_roll, fault
  );
endinterface

// File: rtl/turn_scheduler.sv
// Alternating-turn sequencer for two player controllers: takes dice rolls,
// issues clamped move targets, waits for completion and declares a winner.
module turn_scheduler #(
  parameter int unsigned START_X     = 20,
  parameter int unsigned STEP_PX     = 40,
  parameter int unsigned FLAG_X      = 620,
  parameter int unsigned DICE_MAX    = 6,
  parameter int unsigned TIMEOUT_CYC = 24'hFFFFFF
) (
  input logic             clk,
  input logic             reset_n,
  turn_scheduler_if.slave bus
);
  localparam logic [9:0]  START10 = 10'(START_X);
  localparam logic [9:0]  FLAG10  = 10'(FLAG_X);
  localparam logic [10:0] FLAG11  = 11'(FLAG_X);
  localparam logic [10:0] STEP11  = 11'(STEP_PX);
  localparam logic [2:0]  DMAX    = 3'(DICE_MAX);
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {WAIT_ROLL, ISSUE, WAIT_DONE, GAME_OVER} state_t;

  state_t          state_q;
  logic [1:0][9:0] pos_q, tgt_q;
  logic [1:0]      mst_q;
  logic            act_q, rdy_q, go_q, win_q, bad_q, fault_q;
  logic [23:0]     cnt_q;

  logic [10:0] sum;
  logic [9:0]  tgt_new;
  logic        roll_ok, done_act;

  // 11-bit sum cannot wrap given FLAG_X + DICE_MAX*STEP_PX < 2048
  always_comb begin
    sum      = {1'b0, pos_q[act_q]} + 11'(bus.roll_value) * STEP11;
    tgt_new  = (sum >= FLAG11) ? FLAG10 : sum[9:0];
    roll_ok  = (bus.roll_value != 3'd0) && (bus.roll_value <= DMAX);
    done_act = act_q ? bus.turn_done_p2 : bus.turn_done_p1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_ROLL;
      pos_q   <= {2{START10}};
      tgt_q   <= {2{START10}};
      mst_q   <= '0;
      act_q   <= 1'b0;
      rdy_q   <= 1'b0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
      bad_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mst_q <= '0;
      bad_q <= 1'b0;
      case (state_q)
        WAIT_ROLL: begin
          rdy_q <= 1'b1;
          // new_game outranks a same-cycle roll, which is simply dropped
          if (bus.new_game) begin
            pos_q   <= {2{START10}};
            tgt_q   <= {2{START10}};
            act_q   <= 1'b0;
            go_q    <= 1'b0;
            win_q   <= 1'b0;
            fault_q <= 1'b0;
          end else if (bus.roll_valid && rdy_q) begin
            if (!roll_ok) begin
              bad_q <= 1'b1;
            end else begin
              tgt_q[act_q] <= tgt_new;
              mst_q[act_q] <= 1'b1;
              rdy_q        <= 1'b0;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // done is checked first so it wins over a same-cycle timeout
          if (done_act) begin
            pos_q[act_q] <= tgt_q[act_q];
            if (tgt_q[act_q] == FLAG10) begin
              go_q    <= 1'b1;
              win_q   <= act_q;
              state_q <= GAME_OVER;
            end else begin
              act_q   <= ~act_q;
              rdy_q   <= 1'b1;
              state_q <= WAIT_ROLL;
            end
          end else if (cnt_q == TO_LAST) begin
            fault_q      <= 1'b1;
            tgt_q[act_q] <= pos_q[act_q];
            rdy_q        <= 1'b1;
            state_q      <= WAIT_ROLL;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        GAME_OVER: begin
          if (bus.new_game) begin
            pos_q   <= {2{START10}};
            tgt_q   <= {2{START10}};
            act_q   <= 1'b0;
            go_q    <= 1'b0;
            win_q   <= 1'b0;
            fault_q <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= WAIT_ROLL;
          end
        end
        default: state_q <= WAIT_ROLL;
      endcase
    end
  end

  assign bus.roll_ready    = rdy_q;
  assign bus.move_start_p1 = mst_q[0];
  assign bus.move_start_p2 = mst_q[1];
  assign bus.target_x_p1   = tgt_q[0];
  assign bus.target_x_p2   = tgt_q[1];
  assign bus.active_player = act_q;
  assign bus.game_over     = go_q;
  assign bus.winner        = win_q;
  assign bus.bad_roll      = bad_q;
  assign bus.fault         = fault_q;
endmodule
